// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam int          IM_DEPTH_DEF = 128;
    localparam logic [31:0] TERM_WORD    = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_loader_word_packer.sv
// Packs four accepted bytes little-endian into a 32-bit word.
module word_packer (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_data_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [1:0]  byte_cnt;
    logic [23:0] low_bytes;

    // Byte 3 is merged straight from the input so the full word is ready on the accepting edge.
    assign word_o      = {byte_data_i, low_bytes};
    assign word_full_o = accept_i && (byte_cnt == 2'd3);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (clear_i) begin
            byte_cnt  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (accept_i) begin
            case (byte_cnt)
                2'd0:    low_bytes[7:0]   <= byte_data_i;
                2'd1:    low_bytes[15:8]  <= byte_data_i;
                2'd2:    low_bytes[23:16] <= byte_data_i;
                default: ;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time loader: streams bytes into the instruction memory and holds the CPU in reset until done.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int IM_DEPTH = IM_DEPTH_DEF,
    parameter int ADDR_W   = $clog2(IM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              im_we_o,
    output logic [31:0]       im_addr_o,
    output logic [31:0]       im_data_o,
    output logic              cpu_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_count_o
);

    state_t              state;
    logic [ADDR_W-1:0]   word_idx;
    logic                accept;
    logic                restart;
    logic [31:0]         packed_word;
    logic                word_full;

    assign accept  = byte_valid_i && byte_ready_o;
    assign restart = start_i && (state == S_IDLE || state == S_DONE || state == S_ERR);

    word_packer u_packer (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .clear_i     (restart),
        .accept_i    (accept),
        .byte_data_i (byte_data_i),
        .word_o      (packed_word),
        .word_full_o (word_full)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            word_idx     <= '0;
            byte_ready_o <= 1'b0;
            im_we_o      <= 1'b0;
            im_addr_o    <= 32'd0;
            im_data_o    <= 32'd0;
            cpu_rst_n_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            word_count_o <= '0;
        end else begin
            im_we_o <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state        <= S_RECV;
                        word_idx     <= '0;
                        word_count_o <= '0;
                        byte_ready_o <= 1'b1;
                        busy_o       <= 1'b1;
                        cpu_rst_n_o  <= 1'b0;
                        done_o       <= 1'b0;
                        err_o        <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (word_full) begin
                        state        <= S_WRITE;
                        byte_ready_o <= 1'b0;
                        im_we_o      <= 1'b1;
                        im_addr_o    <= {{(30-ADDR_W){1'b0}}, word_idx, 2'b00};
                        im_data_o    <= packed_word;
                    end
                end
                S_WRITE: begin
                    word_count_o <= word_count_o + (ADDR_W+1)'(1);
                    // Terminator wins over overflow, so a zero word in the last slot still completes.
                    if (im_data_o == TERM_WORD) begin
                        state       <= S_DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        cpu_rst_n_o <= 1'b1;
                    end else if (word_idx == ADDR_W'(IM_DEPTH-1)) begin
                        state  <= S_ERR;
                        busy_o <= 1'b0;
                        err_o  <= 1'b1;
                    end else begin
                        state        <= S_RECV;
                        word_idx     <= word_idx + ADDR_W'(1);
                        byte_ready_o <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a 128-word and a 4-word instance share the byte stream.
module tb_instr_mem_loader;

    typedef struct packed {
        logic             sel;      // 0: depth 128, 1: depth 4
        logic [2:0]       nwords;
        logic [5:0][31:0] words;
        logic [1:0]       gap;      // 0 always valid, 1 toggle, 2 random
        logic             exp_done;
        logic             exp_err;
        logic [7:0]       exp_wc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_valid = 1'b0;
    logic        sel = 1'b0;

    logic        ready_a, we_a, cpu_a, busy_a, done_a, err_a;
    logic [31:0] addr_a, data_a;
    logic [7:0]  wc_a;
    logic        ready_b, we_b, cpu_b, busy_b, done_b, err_b;
    logic [31:0] addr_b, data_b;
    logic [2:0]  wc_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_addr[$], got_data[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic [7:0]  stim_q[$];
    vec_t        vecs[6];

    always #5 clk = ~clk;

    instr_mem_loader #(.IM_DEPTH(128)) dut_a (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_a), .byte_data_i(byte_data),
        .byte_valid_i(byte_valid), .byte_ready_o(ready_a), .im_we_o(we_a), .im_addr_o(addr_a),
        .im_data_o(data_a), .cpu_rst_n_o(cpu_a), .busy_o(busy_a), .done_o(done_a),
        .err_o(err_a), .word_count_o(wc_a)
    );

    instr_mem_loader #(.IM_DEPTH(4)) dut_b (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_b), .byte_data_i(byte_data),
        .byte_valid_i(byte_valid), .byte_ready_o(ready_b), .im_we_o(we_b), .im_addr_o(addr_b),
        .im_data_o(data_b), .cpu_rst_n_o(cpu_b), .busy_o(busy_b), .done_o(done_b),
        .err_o(err_b), .word_count_o(wc_b)
    );

    wire        m_ready = sel ? ready_b : ready_a;
    wire        m_we    = sel ? we_b    : we_a;
    wire        m_cpu   = sel ? cpu_b   : cpu_a;
    wire        m_busy  = sel ? busy_b  : busy_a;
    wire        m_done  = sel ? done_b  : done_a;
    wire        m_err   = sel ? err_b   : err_a;
    wire [31:0] m_addr  = sel ? addr_b  : addr_a;
    wire [31:0] m_data  = sel ? data_b  : data_a;
    wire [7:0]  m_wc    = sel ? {5'd0, wc_b} : wc_a;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Write monitor: record every strobe and confirm no byte can be taken in that cycle.
    always @(negedge clk) begin
        if (rst_n && m_we) begin
            got_addr.push_back(m_addr);
            got_data.push_back(m_data);
            check("ready_during_write", {63'd0, m_ready}, 64'd0);
        end
    end

    task automatic pulse_start(input logic s);
        sel = s;
        @(negedge clk);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check("start_busy",   {63'd0, m_busy},  64'd1);
        check("start_ready",  {63'd0, m_ready}, 64'd1);
        check("start_cpu_rst",{63'd0, m_cpu},   64'd0);
        check("start_wc",     {56'd0, m_wc},    64'd0);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            stim_q.push_back(w[8*k +: 8]);
        end
    endtask

    task automatic send_bytes(input logic [1:0] gap);
        int idx = 0;
        int budget = 0;
        logic v;
        while (idx < stim_q.size() && budget < 3000) begin
            @(negedge clk);
            budget++;
            case (gap)
                2'd0:    v = 1'b1;
                2'd1:    v = budget[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid = v;
            byte_data  = stim_q[idx];
            if (v && m_ready) idx++;
        end
        if (idx < stim_q.size())
            check("send_timeout", 64'(idx), 64'(stim_q.size()));
        @(negedge clk);
        byte_valid = 1'b0;
        stim_q.delete();
    endtask

    // Reference: word i lands at byte address 4*i; stop after a zero word or after the last slot.
    task automatic build_model(input vec_t v);
        int depth = v.sel ? 4 : 128;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < int'(v.nwords); i++) begin
            exp_addr.push_back(32'(i * 4));
            exp_data.push_back(v.words[i]);
            if (v.words[i] == 32'd0 || i == depth - 1) break;
        end
    endtask

    task automatic finish_check(input vec_t v);
        int n = 0;
        int lim;
        build_model(v);
        while (!(m_done || m_err) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done",      {63'd0, m_done},  {63'd0, v.exp_done});
        check("err",       {63'd0, m_err},   {63'd0, v.exp_err});
        check("cpu_rst_n", {63'd0, m_cpu},   {63'd0, v.exp_done});
        check("busy_end",  {63'd0, m_busy},  64'd0);
        check("ready_end", {63'd0, m_ready}, 64'd0);
        check("word_count",{56'd0, m_wc},    {56'd0, v.exp_wc});
        check("n_writes",  64'(got_addr.size()), 64'(exp_addr.size()));
        lim = got_addr.size() < exp_addr.size() ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < lim; i++) begin
            check($sformatf("addr%0d", i), {32'd0, got_addr[i]}, {32'd0, exp_addr[i]});
            check($sformatf("data%0d", i), {32'd0, got_data[i]}, {32'd0, exp_data[i]});
        end
    endtask

    task automatic run_vector(input vec_t v);
        got_addr.delete();
        got_data.delete();
        pulse_start(v.sel);
        for (int i = 0; i < int'(v.nwords); i++) push_word(v.words[i]);
        send_bytes(v.gap);
        finish_check(v);
    endtask

    initial begin
        vec_t hv;
        int   nw;

        vecs[0] = '{sel:1'b0, nwords:3'd2, words:'0, gap:2'd0, exp_done:1'b1, exp_err:1'b0, exp_wc:8'd2};
        vecs[0].words[0] = 32'h2001_0020;
        vecs[1] = vecs[0];
        vecs[1].gap = 2'd1;
        vecs[2] = '{sel:1'b1, nwords:3'd4, words:'0, gap:2'd0, exp_done:1'b0, exp_err:1'b1, exp_wc:8'd4};
        vecs[2].words[0] = 32'h1111_1111;
        vecs[2].words[1] = 32'h2222_2222;
        vecs[2].words[2] = 32'h3333_3333;
        vecs[2].words[3] = 32'h4444_4444;
        vecs[3] = '{sel:1'b1, nwords:3'd4, words:'0, gap:2'd2, exp_done:1'b1, exp_err:1'b0, exp_wc:8'd4};
        vecs[3].words[0] = 32'hDEAD_BEEF;
        vecs[3].words[1] = 32'h0000_0100;
        vecs[3].words[2] = 32'h8000_0000;
        vecs[4] = '{sel:1'b0, nwords:3'd6, words:'0, gap:2'd2, exp_done:1'b1, exp_err:1'b0, exp_wc:8'd6};
        for (int i = 0; i < 5; i++) vecs[4].words[i] = $urandom() | 32'h0000_0001;
        vecs[5] = '{sel:1'b1, nwords:3'd1, words:'0, gap:2'd0, exp_done:1'b1, exp_err:1'b0, exp_wc:8'd1};

        // Reset values
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check("rst_ready", {63'd0, m_ready}, 64'd0);
            check("rst_we",    {63'd0, m_we},    64'd0);
            check("rst_addr",  {32'd0, m_addr},  64'd0);
            check("rst_data",  {32'd0, m_data},  64'd0);
            check("rst_cpu",   {63'd0, m_cpu},   64'd0);
            check("rst_flags", {61'd0, m_busy, m_done, m_err}, 64'd0);
            check("rst_wc",    {56'd0, m_wc},    64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven scenarios; consecutive starts from DONE/ERR exercise reload.
        for (int t = 0; t < 6; t++) begin
            run_vector(vecs[t]);
            if (vecs[t].exp_err) begin
                nw = got_addr.size();
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    byte_valid = 1'b1;
                    byte_data  = 8'h55;
                    check("err_ready", {63'd0, m_ready}, 64'd0);
                end
                @(negedge clk);
                byte_valid = 1'b0;
                check("err_no_write", 64'(got_addr.size()), 64'(nw));
                check("err_hold",     {62'd0, m_err, m_cpu}, 64'd2);
                check("err_wc_hold",  {56'd0, m_wc}, 64'd4);
            end
        end

        // Reset in the middle of a word: the partial bytes must vanish.
        got_addr.delete();
        got_data.delete();
        pulse_start(1'b0);
        stim_q.push_back(8'hA1);
        stim_q.push_back(8'hB2);
        send_bytes(2'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {63'd0, m_ready}, 64'd0);
        check("mid_rst_busy",  {63'd0, m_busy},  64'd0);
        check("mid_rst_cpu",   {63'd0, m_cpu},   64'd0);
        check("mid_rst_addr",  {32'd0, m_addr},  64'd0);
        check("mid_rst_data",  {32'd0, m_data},  64'd0);
        check("mid_rst_wc",    {56'd0, m_wc},    64'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_write", 64'(got_addr.size()), 64'd0);
        rst_n = 1'b1;
        hv = '{sel:1'b0, nwords:3'd2, words:'0, gap:2'd0, exp_done:1'b1, exp_err:1'b0, exp_wc:8'd2};
        hv.words[0] = 32'hAABB_CCDD;
        run_vector(hv);

        // start_i during RECV is ignored: the word keeps its first two bytes.
        got_addr.delete();
        got_data.delete();
        pulse_start(1'b0);
        stim_q.push_back(8'h78);
        stim_q.push_back(8'h56);
        send_bytes(2'd0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("ign_start_busy", {63'd0, m_busy}, 64'd1);
        stim_q.push_back(8'h34);
        stim_q.push_back(8'h12);
        push_word(32'd0);
        send_bytes(2'd1);
        hv.words[0] = 32'h1234_5678;
        finish_check(hv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
